// File: rtl/func_test_sequencer_pkg.sv
// Shared constants, lane indices and state encoding for the functional-test sequencer.
package func_test_pkg;

  localparam logic [3:0] CMD_START_HI = 4'hA;
  localparam logic [7:0] CMD_STOP     = 8'h55;
  localparam logic [7:0] CMD_REQ      = 8'h5A;

  typedef logic [2:0] lane_t;

  localparam lane_t VB_VSEL  = 3'd0;
  localparam lane_t VB_HDVD  = 3'd1;
  localparam lane_t VB_SHIFT = 3'd2;
  localparam lane_t VB_CTRL  = 3'd3;
  localparam lane_t VB_SMP   = 3'd4;

  localparam logic [2:0] TB_IDLE     = 3'd0;
  localparam logic [2:0] TB_WAIT_REQ = 3'd3;

  typedef enum logic [7:0] {
    S_IDLE      = 8'b0000_0001,
    S_CFG       = 8'b0000_0010,
    S_START     = 8'b0000_0100,
    S_SAMPLES   = 8'b0000_1000,
    S_STOP      = 8'b0001_0000,
    S_WAIT_DONE = 8'b0010_0000,
    S_DRAIN     = 8'b0100_0000,
    S_DONE      = 8'b1000_0000
  } seq_state_e;

  function automatic logic [4:0] lane_onehot(input lane_t lane);
    lane_onehot = 5'd1 << lane;
  endfunction

endpackage

// File: rtl/func_test_sequencer_if.sv
// Byte-stream bus between the sequencer (master) and the functional-test block (slave).
interface func_test_sequencer_if;
  logic [7:0] master_data;
  logic [4:0] valid_bus;
  logic [4:0] rdreq_bus;
  logic       have_msg;
  logic [7:0] len;
  logic [7:0] slave_data;
  logic [2:0] dut_state;

  modport master (
    output master_data, valid_bus, rdreq_bus,
    input  have_msg, len, slave_data, dut_state
  );

  modport slave (
    input  master_data, valid_bus, rdreq_bus,
    output have_msg, len, slave_data, dut_state
  );
endinterface

// File: rtl/func_test_sequencer_pacer.sv
// Byte pacer: registers one {lane, byte} request as a one-cycle strobe and holds
// off the next request so strobes are at least GAP cycles apart.
module byte_pacer
  import func_test_pkg::*;
#(
  parameter int unsigned GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  lane_t      req_lane,
  input  logic [7:0] req_byte,
  output logic       ready,
  output logic [4:0] strobe,
  output logic [7:0] data
);

  localparam int unsigned CW = (GAP > 1) ? $clog2(GAP) : 1;

  logic [CW-1:0] gap_q, gap_d;
  logic [4:0]    strobe_q, strobe_d;
  logic [7:0]    data_q, data_d;

  assign ready  = (gap_q == '0);
  assign strobe = strobe_q;
  assign data   = data_q;

  always_comb begin
    gap_d    = gap_q;
    strobe_d = '0;
    data_d   = data_q;
    if (gap_q != '0) gap_d = gap_q - CW'(1);
    if (req_valid && ready) begin
      strobe_d = lane_onehot(req_lane);
      data_d   = req_byte;
      gap_d    = CW'(GAP - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q    <= '0;
      strobe_q <= '0;
      data_q   <= '0;
    end else begin
      gap_q    <= gap_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/func_test_sequencer.sv
// Autonomous sequencer: configures the functional-test block, streams samples,
// stops it and drains the captured BOS words.
module func_test_sequencer
  import func_test_pkg::*;
#(
  parameter int unsigned GAP    = 4,
  parameter int unsigned RD_GAP = 3,
  parameter int unsigned TMO_W  = 20
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 cfg_mode,
  input  logic                 cfg_vsel,
  input  logic                 cfg_hd,
  input  logic                 cfg_vd,
  input  logic [13:0]          cfg_black,
  input  logic [7:0]           cfg_reps,
  input  logic [15:0]          cfg_nsmp,
  input  logic [13:0]          smp_data,
  input  logic                 smp_valid,
  output logic                 smp_ready,
  func_test_sequencer_if.master bus,
  output logic [11:0]          res_data,
  output logic                 res_valid,
  output logic [15:0]          words_rx,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           err
);

  localparam int unsigned RDW = (RD_GAP > 1) ? $clog2(RD_GAP) : 1;

  seq_state_e state_q, state_d;

  logic        mode_q, mode_d, vsel_q, vsel_d, hd_q, hd_d, vd_q, vd_d;
  logic [13:0] black_q, black_d;
  logic [7:0]  reps_q, reps_d;
  logic [2:0]  idx_q, idx_d;
  logic [13:0] smp_q, smp_d;
  logic        have_smp_q, have_smp_d, half_q, half_d;
  logic [15:0] left_q, left_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic        rdreq_q, rdreq_d, cap_q, cap_d;
  logic [RDW-1:0] rdgap_q, rdgap_d;
  logic        odd_q, odd_d;
  logic [7:0]  lo_q, lo_d;
  logic [11:0] res_data_q, res_data_d;
  logic        res_valid_q, res_valid_d;
  logic [15:0] words_q, words_d;
  logic [1:0]  err_q, err_d;

  logic        pace_valid, pace_ready, pace_fire, smp_fire, rd_fire;
  lane_t       pace_lane;
  logic [7:0]  pace_byte;

  byte_pacer #(.GAP(GAP)) u_pacer (
    .clk       (sys_clk),
    .rst       (rst),
    .req_valid (pace_valid),
    .req_lane  (pace_lane),
    .req_byte  (pace_byte),
    .ready     (pace_ready),
    .strobe    (bus.valid_bus),
    .data      (bus.master_data)
  );

  assign pace_fire     = pace_valid && pace_ready;
  assign smp_fire      = smp_valid && smp_ready;
  assign bus.rdreq_bus = {rdreq_q, 4'b0000};
  assign res_data      = res_data_q;
  assign res_valid     = res_valid_q;
  assign words_rx      = words_q;
  assign err           = err_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q <= 1'b0; vsel_q <= 1'b0; hd_q <= 1'b0; vd_q <= 1'b0;
      black_q <= '0; reps_q <= '0; idx_q <= '0;
      smp_q <= '0; have_smp_q <= 1'b0; half_q <= 1'b0; left_q <= '0;
      tmo_q <= '0; rdreq_q <= 1'b0; cap_q <= 1'b0; rdgap_q <= '0;
      odd_q <= 1'b0; lo_q <= '0;
      res_data_q <= '0; res_valid_q <= 1'b0; words_q <= '0; err_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d; vsel_q <= vsel_d; hd_q <= hd_d; vd_q <= vd_d;
      black_q <= black_d; reps_q <= reps_d; idx_q <= idx_d;
      smp_q <= smp_d; have_smp_q <= have_smp_d; half_q <= half_d; left_q <= left_d;
      tmo_q <= tmo_d; rdreq_q <= rdreq_d; cap_q <= cap_d; rdgap_q <= rdgap_d;
      odd_q <= odd_d; lo_q <= lo_d;
      res_data_q <= res_data_d; res_valid_q <= res_valid_d; words_q <= words_d; err_q <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d = mode_q; vsel_d = vsel_q; hd_d = hd_q; vd_d = vd_q;
    black_d = black_q; reps_d = reps_q; idx_d = idx_q;
    smp_d = smp_q; have_smp_d = have_smp_q; half_d = half_q; left_d = left_q;
    tmo_d = tmo_q + TMO_W'(1);
    rdreq_d = rd_fire;
    cap_d = rdreq_q;
    rdgap_d = (rdgap_q != '0) ? rdgap_q - RDW'(1) : rdgap_q;
    odd_d = odd_q; lo_d = lo_q;
    res_data_d = res_data_q; res_valid_d = 1'b0; words_d = words_q; err_d = err_q;

    if (rd_fire) rdgap_d = RDW'(RD_GAP - 1);

    // slave_data is valid in the cycle after the rdreq pulse
    if (cap_q) begin
      if (!odd_q) begin
        lo_d  = bus.slave_data;
        odd_d = 1'b1;
      end else begin
        res_data_d  = {bus.slave_data[3:0], lo_q};
        res_valid_d = 1'b1;
        odd_d       = 1'b0;
        if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          words_d = '0;
          if (cfg_reps == '0 || cfg_nsmp == '0) begin
            err_d   = 2'b01;
            state_d = S_DONE;
          end else begin
            err_d = '0;
            mode_d = cfg_mode; vsel_d = cfg_vsel; hd_d = cfg_hd; vd_d = cfg_vd;
            black_d = cfg_black; reps_d = cfg_reps; left_d = cfg_nsmp;
            idx_d = '0; have_smp_d = 1'b0; half_d = 1'b0; odd_d = 1'b0;
            state_d = S_CFG;
          end
        end
      end
      S_CFG: begin
        if (pace_fire) begin
          if (idx_q == 3'd4) state_d = S_START;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_START: if (pace_fire) state_d = S_SAMPLES;
      S_SAMPLES: begin
        if (smp_fire) begin
          smp_d      = smp_data;
          have_smp_d = 1'b1;
        end
        if (pace_fire) begin
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d     = 1'b0;
            have_smp_d = 1'b0;
            left_d     = left_q - 16'd1;
            if (left_q == 16'd1) state_d = S_STOP;
          end
        end
      end
      S_STOP: if (pace_fire) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (pace_fire) begin
          state_d = S_DRAIN;
        end else if (tmo_q == '1) begin
          err_d   = 2'b10;
          state_d = S_DONE;
        end
      end
      S_DRAIN: begin
        if (rd_fire) tmo_d = '0;
        if (bus.dut_state == TB_IDLE && !rdreq_q && !cap_q) begin
          state_d = S_DONE;
        end else if (tmo_q == '1 && !rd_fire) begin
          err_d   = 2'b10;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) tmo_d = '0;
  end

  always_comb begin
    pace_valid = 1'b0;
    pace_lane  = VB_VSEL;
    pace_byte  = '0;
    smp_ready  = 1'b0;
    rd_fire    = 1'b0;
    busy       = !(state_q == S_IDLE || state_q == S_DONE);
    done       = (state_q == S_DONE);
    unique case (state_q)
      S_CFG: begin
        pace_valid = 1'b1;
        unique case (idx_q)
          3'd0:    begin pace_lane = VB_VSEL;  pace_byte = {7'b0, vsel_q};       end
          3'd1:    begin pace_lane = VB_HDVD;  pace_byte = {6'b0, hd_q, vd_q};   end
          3'd2:    begin pace_lane = VB_SHIFT; pace_byte = black_q[7:0];         end
          3'd3:    begin pace_lane = VB_SHIFT; pace_byte = {2'b0, black_q[13:8]}; end
          default: begin pace_lane = VB_SHIFT; pace_byte = reps_q;               end
        endcase
      end
      S_START: begin
        pace_valid = 1'b1;
        pace_lane  = VB_CTRL;
        pace_byte  = {CMD_START_HI, 3'b000, mode_q};
      end
      S_SAMPLES: begin
        smp_ready  = !have_smp_q;
        pace_valid = have_smp_q;
        pace_lane  = VB_SMP;
        pace_byte  = half_q ? {2'b0, smp_q[13:8]} : smp_q[7:0];
      end
      S_STOP: begin
        pace_valid = 1'b1;
        pace_lane  = VB_CTRL;
        pace_byte  = CMD_STOP;
      end
      S_WAIT_DONE: begin
        pace_valid = (bus.dut_state == TB_WAIT_REQ);
        pace_lane  = VB_CTRL;
        pace_byte  = CMD_REQ;
      end
      S_DRAIN: begin
        // no new read once the block reports idle, so exit never strands a pulse
        rd_fire = bus.have_msg && (bus.len != '0) && !rdreq_q && !cap_q &&
                  (rdgap_q == '0) && (bus.dut_state != TB_IDLE);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_func_test_sequencer.sv
// Directed bench for func_test_sequencer with a stub sample source and stub slave FIFO.
module tb_func_test_sequencer;
  import func_test_pkg::*;

  localparam int unsigned GAP = 4, RD_GAP = 3, TMO_W = 8;

  logic        sys_clk = 1'b0, rst = 1'b1, go = 1'b0;
  logic        cfg_mode = 1'b0, cfg_vsel = 1'b0, cfg_hd = 1'b0, cfg_vd = 1'b0;
  logic [13:0] cfg_black = '0;
  logic [7:0]  cfg_reps = '0;
  logic [15:0] cfg_nsmp = '0;
  logic [13:0] smp_data;
  logic        smp_valid, smp_ready;
  logic [11:0] res_data;
  logic        res_valid, busy, done;
  logic [15:0] words_rx;
  logic [1:0]  err;

  int unsigned total = 0, bad = 0;

  func_test_sequencer_if bus ();

  func_test_sequencer #(.GAP(GAP), .RD_GAP(RD_GAP), .TMO_W(TMO_W)) dut (
    .sys_clk(sys_clk), .rst(rst), .go(go),
    .cfg_mode(cfg_mode), .cfg_vsel(cfg_vsel), .cfg_hd(cfg_hd), .cfg_vd(cfg_vd),
    .cfg_black(cfg_black), .cfg_reps(cfg_reps), .cfg_nsmp(cfg_nsmp),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .bus(bus),
    .res_data(res_data), .res_valid(res_valid), .words_rx(words_rx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  // stub sample source
  logic [13:0] sarr [0:7];
  int unsigned snum = 0, sidx = 0;
  logic src_clr = 1'b0;
  assign smp_valid = (sidx < snum);
  assign smp_data  = sarr[sidx[2:0]];
  always @(posedge sys_clk)
    if (src_clr) sidx <= 0;
    else if (smp_valid && smp_ready) sidx <= sidx + 1;

  // stub slave FIFO
  logic [7:0] sl_arr [0:7];
  int unsigned sl_num = 0, sl_idx = 0;
  logic sl_clr = 1'b0;
  assign bus.have_msg = (sl_idx < sl_num);
  assign bus.len      = 8'(sl_num - sl_idx);
  always @(posedge sys_clk)
    if (sl_clr) sl_idx <= 0;
    else if (bus.rdreq_bus[4]) begin
      bus.slave_data <= sl_arr[sl_idx[2:0]];
      sl_idx <= sl_idx + 1;
    end

  // event logs
  int unsigned cyc = 0;
  logic [4:0]  lg_vb [$];
  logic [7:0]  lg_d  [$];
  int unsigned lg_c  [$];
  int unsigned rd_c  [$];
  logic [11:0] res_l [$];
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(negedge sys_clk) begin
    if (bus.valid_bus != 5'd0) begin
      lg_vb.push_back(bus.valid_bus);
      lg_d.push_back(bus.master_data);
      lg_c.push_back(cyc);
    end
    if (bus.rdreq_bus[4]) rd_c.push_back(cyc);
    if (res_valid) res_l.push_back(res_data);
  end

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic pulse_go();
    go = 1'b1; tick(); go = 1'b0;
  endtask

  task automatic wait_log(input int unsigned n, input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget && !ok; i++) begin
      @(negedge sys_clk);
      if (lg_vb.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.dut_state = TB_IDLE;
    repeat (2) tick();
    @(negedge sys_clk);
    total++; if (bus.valid_bus !== 5'd0) begin bad++; $display("FAIL reset_valid_bus got=%h exp=00", bus.valid_bus); end
    total++; if (bus.master_data !== 8'd0) begin bad++; $display("FAIL reset_master_data got=%h exp=00", bus.master_data); end
    total++; if (bus.rdreq_bus !== 5'd0) begin bad++; $display("FAIL reset_rdreq got=%h exp=00", bus.rdreq_bus); end
    total++; if ({smp_ready, res_valid, busy, done} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {smp_ready, res_valid, busy, done}); end
    total++; if ({res_data, words_rx, err} !== 30'd0) begin bad++; $display("FAIL reset_data got=%h/%h/%b exp=0", res_data, words_rx, err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_config_stream();
    logic [4:0] ev [9] = '{5'h01, 5'h02, 5'h04, 5'h04, 5'h04, 5'h08, 5'h10, 5'h10, 5'h08};
    logic [7:0] ed [9] = '{8'h01, 8'h02, 8'hBC, 8'h2A, 8'h10, 8'hA1, 8'h34, 8'h12, 8'h55};
    int unsigned base;
    bit ok;
    cfg_vsel = 1'b1; cfg_hd = 1'b1; cfg_vd = 1'b0; cfg_black = 14'h2ABC;
    cfg_reps = 8'h10; cfg_mode = 1'b1; cfg_nsmp = 16'd1;
    snum = 0; src_clr = 1'b1; tick(); src_clr = 1'b0;
    sarr[0] = 14'h1234; snum = 1;
    base = lg_vb.size();
    pulse_go();
    wait_log(base + 9, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL cfg_stream_count got=%0d exp=9", lg_vb.size() - base); end
    for (int unsigned k = 0; k < 9; k++) begin
      if (base + k < lg_vb.size()) begin
        total++;
        if (lg_vb[base+k] !== ev[k] || lg_d[base+k] !== ed[k]) begin
          bad++; $display("FAIL cfg_stream_byte%0d got=%h:%h exp=%h:%h", k, lg_vb[base+k], lg_d[base+k], ev[k], ed[k]);
        end
        if (k > 0) begin
          total++;
          if (lg_c[base+k] - lg_c[base+k-1] < GAP) begin
            bad++; $display("FAIL cfg_stream_gap%0d got=%0d exp>=%0d", k, lg_c[base+k] - lg_c[base+k-1], GAP);
          end
        end
      end
    end
    total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL cfg_wait_busy got=%b exp=10", {busy, done}); end
  endtask

  task automatic test_drain();
    int unsigned base, rbase, rdbase;
    bit ok;
    sl_num = 0; sl_clr = 1'b1; tick(); sl_clr = 1'b0;
    sl_arr[0] = 8'h21; sl_arr[1] = 8'h03; sl_arr[2] = 8'hFF; sl_arr[3] = 8'h0F;
    sl_num = 4;
    base = lg_vb.size(); rbase = res_l.size(); rdbase = rd_c.size();
    bus.dut_state = TB_WAIT_REQ;
    wait_log(base + 1, 50, ok);
    total++;
    if (!ok || lg_vb[base] !== 5'h08 || lg_d[base] !== 8'h5A) begin
      bad++; $display("FAIL drain_req_byte got_ok=%0d exp=08:5A", ok);
    end
    for (int unsigned i = 0; i < 200 && res_l.size() < rbase + 2; i++) @(negedge sys_clk);
    bus.dut_state = TB_IDLE;
    for (int unsigned i = 0; i < 50 && !done; i++) @(negedge sys_clk);
    total++; if (res_l.size() != rbase + 2) begin bad++; $display("FAIL drain_word_count got=%0d exp=2", res_l.size() - rbase); end
    if (res_l.size() >= rbase + 2) begin
      total++; if (res_l[rbase] !== 12'h321) begin bad++; $display("FAIL drain_word0 got=%h exp=321", res_l[rbase]); end
      total++; if (res_l[rbase+1] !== 12'hFFF) begin bad++; $display("FAIL drain_word1 got=%h exp=fff", res_l[rbase+1]); end
    end
    total++; if (words_rx !== 16'd2) begin bad++; $display("FAIL drain_words_rx got=%0d exp=2", words_rx); end
    total++; if ({done, err} !== 3'b100) begin bad++; $display("FAIL drain_done got=%b exp=100", {done, err}); end
    total++; if (rd_c.size() != rdbase + 4) begin bad++; $display("FAIL drain_reads got=%0d exp=4", rd_c.size() - rdbase); end
    for (int unsigned k = rdbase + 1; k < rd_c.size(); k++) begin
      total++;
      if (rd_c[k] - rd_c[k-1] < RD_GAP) begin bad++; $display("FAIL drain_rd_gap got=%0d exp>=%0d", rd_c[k] - rd_c[k-1], RD_GAP); end
    end
  endtask

  task automatic test_bad_config();
    int unsigned base;
    base = lg_vb.size();
    cfg_reps = 8'h00;
    pulse_go();
    tick();
    @(negedge sys_clk);
    total++; if ({done, err, busy} !== 4'b1010) begin bad++; $display("FAIL badcfg_status got=%b exp=1010", {done, err, busy}); end
    repeat (10) @(negedge sys_clk);
    total++; if (lg_vb.size() != base) begin bad++; $display("FAIL badcfg_no_strobes got=%0d exp=0", lg_vb.size() - base); end
    cfg_reps = 8'h10;
  endtask

  task automatic test_stall_timeout();
    logic [7:0] ed [7] = '{8'h11, 8'h11, 8'h22, 8'h2F, 8'h33, 8'h33, 8'h55};
    int unsigned base, n, c55;
    bit ok;
    cfg_nsmp = 16'd3;
    snum = 0; src_clr = 1'b1; tick(); src_clr = 1'b0;
    sarr[0] = 14'h1111; sarr[1] = 14'h2F22; sarr[2] = 14'h3333; snum = 1;
    base = lg_vb.size();
    pulse_go();
    wait_log(base + 8, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_first_sample got=%0d exp=8", lg_vb.size() - base); end
    n = lg_vb.size();
    repeat (50) @(negedge sys_clk);
    total++; if (lg_vb.size() != n) begin bad++; $display("FAIL stall_quiet got=%0d exp=0", lg_vb.size() - n); end
    total++; if (smp_ready !== 1'b1) begin bad++; $display("FAIL stall_ready got=%b exp=1", smp_ready); end
    snum = 3;
    wait_log(base + 13, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_resume_count got=%0d exp=13", lg_vb.size() - base); end
    for (int unsigned k = 0; k < 7; k++) begin
      if (base + 6 + k < lg_vb.size()) begin
        total++;
        if (lg_d[base+6+k] !== ed[k] || lg_vb[base+6+k] !== ((k == 6) ? 5'h08 : 5'h10)) begin
          bad++; $display("FAIL stall_byte%0d got=%h:%h exp=%h", k, lg_vb[base+6+k], lg_d[base+6+k], ed[k]);
        end
      end
    end
    c55 = (lg_c.size() > 0) ? lg_c[lg_c.size()-1] : cyc;
    while (cyc < c55 + 250) @(negedge sys_clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b exp=0", done); end
    while (!done && cyc < c55 + 300) @(negedge sys_clk);
    total++; if ({done, err} !== 3'b110) begin bad++; $display("FAIL timeout_status got=%b exp=110", {done, err}); end
    total++; if (cyc - c55 < 255 || cyc - c55 > 257) begin bad++; $display("FAIL timeout_cycles got=%0d exp=256", cyc - c55); end
  endtask

  task automatic test_reset_mid_samples();
    int unsigned base;
    bit ok;
    cfg_nsmp = 16'd5;
    snum = 0; src_clr = 1'b1; tick(); src_clr = 1'b0;
    for (int unsigned i = 0; i < 5; i++) sarr[i] = 14'(14'h0101 * (i + 1));
    snum = 5;
    base = lg_vb.size();
    pulse_go();
    wait_log(base + 11, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_reach got=%0d exp=11", lg_vb.size() - base); end
    rst = 1'b1;
    tick();
    @(negedge sys_clk);
    total++; if ({bus.valid_bus, bus.master_data, bus.rdreq_bus} !== 18'd0) begin bad++; $display("FAIL rstmid_bus got=%h/%h/%h exp=0", bus.valid_bus, bus.master_data, bus.rdreq_bus); end
    total++; if ({smp_ready, busy, done, err, res_valid, words_rx, res_data} !== 34'd0) begin bad++; $display("FAIL rstmid_outputs got=%b%b%b%b exp=0", smp_ready, busy, done, err); end
    rst = 1'b0;
    n_quiet: begin
      int unsigned n;
      n = lg_vb.size();
      repeat (10) @(negedge sys_clk);
      total++; if (lg_vb.size() != n) begin bad++; $display("FAIL rstmid_quiet got=%0d exp=0", lg_vb.size() - n); end
    end
    cfg_nsmp = 16'd1;
    base = lg_vb.size();
    pulse_go();
    wait_log(base + 1, 50, ok);
    total++;
    if (!ok || lg_vb[base] !== 5'h01 || lg_d[base] !== 8'h01) begin
      bad++; $display("FAIL rstmid_restart got_ok=%0d exp=01:01", ok);
    end
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dut_state = TB_IDLE;
    test_reset();
    test_config_stream();
    test_drain();
    test_bad_config();
    test_stall_timeout();
    test_reset_mid_samples();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
